// File: rtl/thinpad_bus_pkg.sv
// Shared constants for the base-SRAM bus arbiter: FSM encoding, bus widths, port IDs.
package thinpad_bus_pkg;
  localparam int SRAM_AW = 20;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 8;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] READ   = 3'd1;
  localparam logic [2:0] WSETUP = 3'd2;
  localparam logic [2:0] WPULSE = 3'd3;
  localparam logic [2:0] WHOLD  = 3'd4;

  localparam logic PORT_IF  = 1'b0;
  localparam logic PORT_MEM = 1'b1;
endpackage

// File: rtl/sram_bus_arbiter.sv
// Arbitrates the CPU fetch and data ports onto the single base SRAM and sequences
// its read/write timing; every SRAM-facing output and both acks are registered.
//
// state  | meaning
// IDLE   | SRAM deselected, grant mem over if
// READ   | CE/OE low, wait counter runs, then capture read data
// WSETUP | addr/data/CE stable before the WE pulse
// WPULSE | WE low
// WHOLD  | WE high again, addr/data still held
module sram_bus_arbiter
  import thinpad_bus_pkg::*;
#(
  parameter int READ_WAIT   = 1,
  parameter int WRITE_SETUP = 1,
  parameter int WRITE_PULSE = 1,
  parameter int WRITE_HOLD  = 1,
  parameter int ADDR_LSB    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [31:0]         if_addr_i,
  output logic [DATA_W-1:0]   if_data_o,
  output logic                if_ack_o,
  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [31:0]         mem_addr_i,
  input  logic [3:0]          mem_sel_i,
  input  logic [DATA_W-1:0]   mem_data_i,
  output logic [DATA_W-1:0]   mem_data_o,
  output logic                mem_ack_o,
  output logic                stall_o,
  output logic [SRAM_AW-1:0]  sram_addr_o,
  output logic [3:0]          sram_be_n_o,
  output logic                sram_ce_n_o,
  output logic                sram_oe_n_o,
  output logic                sram_we_n_o,
  output logic [DATA_W-1:0]   sram_data_o,
  output logic                sram_data_oe_o,
  input  logic [DATA_W-1:0]   sram_data_i
);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'(WRITE_SETUP - 1);
  localparam logic [CNT_W-1:0] WP_LOAD = CNT_W'(WRITE_PULSE - 1);
  localparam logic [CNT_W-1:0] WH_LOAD = CNT_W'(WRITE_HOLD - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             port_q;
  logic             mem_elig;
  logic             if_elig;
  logic [31:0]      grant_addr;
  logic             unused_addr;

  // A port is ineligible in its own ack cycle so a held request is not served twice.
  assign mem_elig    = mem_req_i & ~mem_ack_o;
  assign if_elig     = if_req_i & ~if_ack_o;
  assign grant_addr  = mem_elig ? mem_addr_i : if_addr_i;
  assign unused_addr = ^grant_addr;

  assign stall_o = (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      port_q         <= PORT_IF;
      sram_addr_o    <= '0;
      sram_be_n_o    <= 4'hF;
      sram_ce_n_o    <= 1'b1;
      sram_oe_n_o    <= 1'b1;
      sram_we_n_o    <= 1'b1;
      sram_data_oe_o <= 1'b0;
      sram_data_o    <= '0;
      if_ack_o       <= 1'b0;
      mem_ack_o      <= 1'b0;
      if_data_o      <= '0;
      mem_data_o     <= '0;
    end else begin
      if_ack_o  <= 1'b0;
      mem_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_elig || if_elig) begin
            port_q      <= mem_elig ? PORT_MEM : PORT_IF;
            sram_addr_o <= grant_addr[ADDR_LSB +: SRAM_AW];
            sram_be_n_o <= mem_elig ? ~mem_sel_i : 4'h0;
            sram_ce_n_o <= 1'b0;
            if (mem_elig && mem_we_i) begin
              state          <= WSETUP;
              cnt            <= WS_LOAD;
              sram_data_o    <= mem_data_i;
              sram_data_oe_o <= 1'b1;
            end else begin
              state       <= READ;
              cnt         <= RD_LOAD;
              sram_oe_n_o <= 1'b0;
            end
          end
        end
        READ: begin
          if (cnt == '0) begin
            if (port_q == PORT_MEM) begin
              mem_data_o <= sram_data_i;
              mem_ack_o  <= 1'b1;
            end else begin
              if_data_o <= sram_data_i;
              if_ack_o  <= 1'b1;
            end
            state       <= IDLE;
            sram_ce_n_o <= 1'b1;
            sram_oe_n_o <= 1'b1;
            sram_be_n_o <= 4'hF;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WSETUP: begin
          if (cnt == '0) begin
            state       <= WPULSE;
            cnt         <= WP_LOAD;
            sram_we_n_o <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WPULSE: begin
          if (cnt == '0) begin
            state       <= WHOLD;
            cnt         <= WH_LOAD;
            sram_we_n_o <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WHOLD: begin
          if (cnt == '0) begin
            state          <= IDLE;
            mem_ack_o      <= 1'b1;
            sram_ce_n_o    <= 1'b1;
            sram_data_oe_o <= 1'b0;
            sram_be_n_o    <= 4'hF;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
